// File: rtl/regbank_write_arbiter.sv
// Two-requester write arbiter for an enable-gated register bank: generates the bank tick,
// one-hot reg_we and shared reg_d. Optional define REGARB_FIXED_PRIORITY_EN makes A always win.
module regbank_write_arbiter #(
    parameter int NR_OF_BITS = 8,
    parameter int ADDR_BITS  = 3,
    parameter int TICK_DIV   = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        a_req,
    input  logic [ADDR_BITS-1:0]        a_addr,
    input  logic [NR_OF_BITS-1:0]       a_data,
    output logic                        a_ack,
    input  logic                        b_req,
    input  logic [ADDR_BITS-1:0]        b_addr,
    input  logic [NR_OF_BITS-1:0]       b_data,
    output logic                        b_ack,
    output logic                        tick,
    output logic [(1<<ADDR_BITS)-1:0]   reg_we,
    output logic [NR_OF_BITS-1:0]       reg_d,
    output logic                        busy,
    output logic                        grant_b
);
    localparam int NREG  = 1 << ADDR_BITS;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    function automatic logic [NREG-1:0] addr_onehot(input logic [ADDR_BITS-1:0] addr);
        logic [NREG-1:0] v;
        v       = {NREG{1'b0}};
        v[addr] = 1'b1;
        return v;
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_tick_cnt;
    logic                   r_tick;
    logic [NREG-1:0]        r_we;
    logic [NREG-1:0]        w_we_nxt;
    logic [NR_OF_BITS-1:0]  r_d;
    logic [NR_OF_BITS-1:0]  w_d_nxt;
    logic                   r_a_ack;
    logic                   w_a_ack_nxt;
    logic                   r_b_ack;
    logic                   w_b_ack_nxt;
    logic                   r_busy;
    logic                   r_grant_b;
    logic                   w_grant_b_nxt;
    logic                   w_pick_b;
    logic [ADDR_BITS-1:0]   w_sel_addr;
    logic [NR_OF_BITS-1:0]  w_sel_data;

    // Free-running tick divider; tick is registered one cycle after the counter hits its last value
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= {CNT_W{1'b0}};
            r_tick     <= 1'b0;
        end else begin
            r_tick <= (r_tick_cnt == CNT_LAST);
            if (r_tick_cnt == CNT_LAST) begin
                r_tick_cnt <= {CNT_W{1'b0}};
            end else begin
                r_tick_cnt <= r_tick_cnt + CNT_W'(1);
            end
        end
    end

`ifdef REGARB_FIXED_PRIORITY_EN
    assign w_pick_b = b_req & ~a_req;
`else
    logic r_prio_b;

    assign w_pick_b = b_req & (~a_req | r_prio_b);

    // Round-robin pointer: favour whichever requester was not served by the latest grant
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prio_b <= 1'b0;
        end else if ((r_state == ST_IDLE) && (a_req || b_req)) begin
            r_prio_b <= ~w_pick_b;
        end else begin
            r_prio_b <= r_prio_b;
        end
    end
`endif

    assign w_sel_addr = w_pick_b ? b_addr : a_addr;
    assign w_sel_data = w_pick_b ? b_data : a_data;

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_we_nxt      = r_we;
        w_d_nxt       = r_d;
        w_grant_b_nxt = r_grant_b;
        w_a_ack_nxt   = 1'b0;
        w_b_ack_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    w_grant_b_nxt = w_pick_b;
                    w_d_nxt       = w_sel_data;
                    w_we_nxt      = addr_onehot(w_sel_addr);
                    w_state_nxt   = ST_WRITE;
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // The bank captures reg_d on this same edge, so the enable can drop with it
                if (r_tick) begin
                    w_we_nxt    = {NREG{1'b0}};
                    w_a_ack_nxt = ~r_grant_b;
                    w_b_ack_nxt = r_grant_b;
                    w_state_nxt = ST_ACK;
                end else begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_we_nxt    = {NREG{1'b0}};
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_we      <= {NREG{1'b0}};
            r_d       <= {NR_OF_BITS{1'b0}};
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_busy    <= 1'b0;
            r_grant_b <= 1'b0;
        end else begin
            r_we      <= w_we_nxt;
            r_d       <= w_d_nxt;
            r_a_ack   <= w_a_ack_nxt;
            r_b_ack   <= w_b_ack_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_grant_b <= w_grant_b_nxt;
        end
    end

    assign tick    = r_tick;
    assign reg_we  = r_we;
    assign reg_d   = r_d;
    assign a_ack   = r_a_ack;
    assign b_ack   = r_b_ack;
    assign busy    = r_busy;
    assign grant_b = r_grant_b;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed self-checking bench for regbank_write_arbiter: a TICK_DIV=4 instance for the
// main scenarios and a TICK_DIV=1 instance for back-to-back throughput.
module tb_regbank_write_arbiter;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       a_req, b_req;
    logic [2:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic       a_ack, b_ack, tick, busy, grant_b;
    logic [7:0] reg_we, reg_d;

    logic       t1_a_req, t1_b_req;
    logic [2:0] t1_a_addr, t1_b_addr;
    logic [7:0] t1_a_data, t1_b_data;
    logic       t1_a_ack, t1_b_ack, t1_tick, t1_busy, t1_grant_b;
    logic [7:0] t1_reg_we, t1_reg_d;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    regbank_write_arbiter #(.NR_OF_BITS(8), .ADDR_BITS(3), .TICK_DIV(4)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
        .tick(tick), .reg_we(reg_we), .reg_d(reg_d), .busy(busy), .grant_b(grant_b)
    );

    regbank_write_arbiter #(.NR_OF_BITS(8), .ADDR_BITS(3), .TICK_DIV(1)) dut1 (
        .clock(clock), .reset(reset),
        .a_req(t1_a_req), .a_addr(t1_a_addr), .a_data(t1_a_data), .a_ack(t1_a_ack),
        .b_req(t1_b_req), .b_addr(t1_b_addr), .b_data(t1_b_data), .b_ack(t1_b_ack),
        .tick(t1_tick), .reg_we(t1_reg_we), .reg_d(t1_reg_d), .busy(t1_busy), .grant_b(t1_grant_b)
    );

    // Waits (bounded) for an ack on the TICK_DIV=4 instance, watching reg_we/reg_d on the way.
    task automatic wait_ack(input logic [7:0] exp_we, input logic [7:0] exp_d, input int budget,
                            output int cyc, output logic got, output logic got_b,
                            output logic prev_t, output logic hold_ok);
        cyc = 0; got = 1'b0; got_b = 1'b0; hold_ok = 1'b1; prev_t = tick;
        while (!got && cyc < budget) begin
            @(negedge clock);
            cyc++;
            if (a_ack || b_ack) begin
                got   = 1'b1;
                got_b = b_ack;
                if (a_ack && b_ack) hold_ok = 1'b0;
            end else begin
                if (busy && (reg_we !== exp_we || reg_d !== exp_d)) hold_ok = 1'b0;
                if (!busy && reg_we !== 8'h00) hold_ok = 1'b0;
                prev_t = tick;
            end
        end
    endtask

    task automatic test_reset();
        logic exp_t;
        @(negedge clock);
        @(negedge clock);
        checks++;
        if ({tick, a_ack, b_ack, busy, grant_b, reg_we, reg_d} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {tick, a_ack, b_ack, busy, grant_b, reg_we, reg_d});
        end
        checks++;
        if ({t1_tick, t1_a_ack, t1_b_ack, t1_busy, t1_grant_b, t1_reg_we, t1_reg_d} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs_t1: got %h expected 0", {t1_tick, t1_a_ack, t1_b_ack, t1_busy, t1_grant_b, t1_reg_we, t1_reg_d});
        end
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            exp_t = ((i % 4) == 0);
            checks++;
            if (tick !== exp_t) begin
                errors++;
                $display("FAIL tick_cycle%0d: got %b expected %b", i, tick, exp_t);
            end
        end
    endtask

    task automatic test_a_only();
        int cyc; logic got, got_b, prev_t, hold_ok;
        a_req = 1'b1; a_addr = 3'd5; a_data = 8'hA5;
        wait_ack(8'h20, 8'hA5, 10, cyc, got, got_b, prev_t, hold_ok);
        checks++;
        if (got !== 1'b1 || got_b !== 1'b0) begin
            errors++; $display("FAIL a_only_ack: got ack=%b b=%b expected ack=1 b=0", got, got_b);
        end
        checks++;
        if (hold_ok !== 1'b1) begin
            errors++; $display("FAIL a_only_hold: reg_we/reg_d deviated, expected 20/a5");
        end
        checks++;
        if (prev_t !== 1'b1) begin
            errors++; $display("FAIL a_only_commit_tick: got tick=%b at commit edge expected 1", prev_t);
        end
        checks++;
        if (cyc < 2 || cyc > 5) begin
            errors++; $display("FAIL a_only_latency: got %0d expected 2..5", cyc);
        end
        checks++;
        if (reg_we !== 8'h00 || grant_b !== 1'b0) begin
            errors++; $display("FAIL a_only_ack_state: got we=%h grant_b=%b expected 00/0", reg_we, grant_b);
        end
        a_req = 1'b0;
        @(negedge clock);
        checks++;
        if ({a_ack, b_ack, busy} !== 3'b000) begin
            errors++; $display("FAIL a_only_pulse: got ack/back/busy=%b expected 000", {a_ack, b_ack, busy});
        end
    endtask

    task automatic test_round_robin();
        int cyc; logic got, got_b, prev_t, hold_ok;
        logic [2:0] exp_seq;
        logic [7:0] ew, ed;
`ifdef REGARB_FIXED_PRIORITY_EN
        exp_seq = 3'b000;
`else
        exp_seq = 3'b010;
`endif
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        a_req = 1'b1; a_addr = 3'd1; a_data = 8'h11;
        b_req = 1'b1; b_addr = 3'd2; b_data = 8'h22;
        for (int k = 0; k < 3; k++) begin
            ew = exp_seq[k] ? 8'h04 : 8'h02;
            ed = exp_seq[k] ? 8'h22 : 8'h11;
            wait_ack(ew, ed, 12, cyc, got, got_b, prev_t, hold_ok);
            checks++;
            if (got !== 1'b1 || got_b !== exp_seq[k] || grant_b !== exp_seq[k]) begin
                errors++;
                $display("FAIL rr_grant%0d: got ack=%b b=%b grant_b=%b expected ack=1 b=%b", k, got, got_b, grant_b, exp_seq[k]);
            end
            checks++;
            if (hold_ok !== 1'b1) begin
                errors++; $display("FAIL rr_hold%0d: reg_we/reg_d deviated, expected %h/%h", k, ew, ed);
            end
            if (k == 2) begin
                a_req = 1'b0; b_req = 1'b0;
            end
            @(negedge clock);
            checks++;
            if ({a_ack, b_ack} !== 2'b00) begin
                errors++; $display("FAIL rr_pulse%0d: got acks=%b expected 00", k, {a_ack, b_ack});
            end
        end
    endtask

    task automatic test_data_change();
        int cyc; logic got, got_b, prev_t, hold_ok;
        a_req = 1'b1; a_addr = 3'd3; a_data = 8'h11;
        @(negedge clock);
        checks++;
        if (reg_we !== 8'h08 || reg_d !== 8'h11) begin
            errors++; $display("FAIL chg_latch: got %h/%h expected 08/11", reg_we, reg_d);
        end
        a_data = 8'h22; a_addr = 3'd6;
        wait_ack(8'h08, 8'h11, 10, cyc, got, got_b, prev_t, hold_ok);
        checks++;
        if (got !== 1'b1 || got_b !== 1'b0 || hold_ok !== 1'b1 || reg_d !== 8'h11) begin
            errors++;
            $display("FAIL chg_commit: got ack=%b b=%b hold=%b d=%h expected 1/0/1/11", got, got_b, hold_ok, reg_d);
        end
        a_req = 1'b0;
        @(negedge clock);
        checks++;
        if (a_ack !== 1'b0) begin
            errors++; $display("FAIL chg_pulse: got %b expected 0", a_ack);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; logic got, got_b, prev_t, hold_ok;
        a_req = 1'b1; a_addr = 3'd4; a_data = 8'h5A;
        @(negedge clock);
        checks++;
        if (reg_we !== 8'h10 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_grant: got we=%h busy=%b expected 10/1", reg_we, busy);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (reg_we !== 8'h00 || busy !== 1'b0 || a_ack !== 1'b0) begin
            errors++; $display("FAIL mid_async: got we=%h busy=%b ack=%b expected 00/0/0", reg_we, busy, a_ack);
        end
        @(negedge clock);
        a_req = 1'b0;
        checks++;
        if (a_ack !== 1'b0 || reg_we !== 8'h00) begin
            errors++; $display("FAIL mid_held: got ack=%b we=%h expected 0/00", a_ack, reg_we);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({busy, a_ack, reg_we} !== 10'd0) begin
            errors++; $display("FAIL mid_release: got %h expected 0", {busy, a_ack, reg_we});
        end
        a_req = 1'b1; a_addr = 3'd7; a_data = 8'hC3;
        wait_ack(8'h80, 8'hC3, 10, cyc, got, got_b, prev_t, hold_ok);
        checks++;
        if (got !== 1'b1 || got_b !== 1'b0 || hold_ok !== 1'b1 || cyc > 5) begin
            errors++;
            $display("FAIL mid_next: got ack=%b b=%b hold=%b cyc=%0d expected 1/0/1/<=5", got, got_b, hold_ok, cyc);
        end
        a_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic exp_ack, exp_busy;
        logic [7:0] exp_we;
        checks++;
        if (t1_tick !== 1'b1) begin
            errors++; $display("FAIL b2b_tick_high: got %b expected 1", t1_tick);
        end
        t1_a_req = 1'b1; t1_a_addr = 3'd0; t1_a_data = 8'h3C;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clock);
            exp_ack  = ((i % 3) == 2);
            exp_busy = ((i % 3) != 0);
            exp_we   = ((i % 3) == 1) ? 8'h01 : 8'h00;
            checks++;
            if (t1_a_ack !== exp_ack || t1_b_ack !== 1'b0) begin
                errors++; $display("FAIL b2b_ack%0d: got a=%b b=%b expected a=%b b=0", i, t1_a_ack, t1_b_ack, exp_ack);
            end
            checks++;
            if (t1_busy !== exp_busy || t1_reg_we !== exp_we) begin
                errors++; $display("FAIL b2b_busy%0d: got busy=%b we=%h expected %b/%h", i, t1_busy, t1_reg_we, exp_busy, exp_we);
            end
        end
        t1_a_req = 1'b0;
        checks++;
        if (t1_reg_d !== 8'h3C || t1_grant_b !== 1'b0) begin
            errors++; $display("FAIL b2b_data: got d=%h grant_b=%b expected 3c/0", t1_reg_d, t1_grant_b);
        end
    endtask

    initial begin
        a_req = 1'b0; a_addr = 3'd0; a_data = 8'h00;
        b_req = 1'b0; b_addr = 3'd0; b_data = 8'h00;
        t1_a_req = 1'b0; t1_a_addr = 3'd0; t1_a_data = 8'h00;
        t1_b_req = 1'b0; t1_b_addr = 3'd0; t1_b_data = 8'h00;
        test_reset();
        test_a_only();
        test_round_robin();
        test_data_change();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
